// File: rtl/fb_arbiter.sv
// rtl/fb_arbiter.sv - fixed-priority display/writer arbiter for a single-port frame buffer RAM
module fb_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 12,
  parameter int WBUF_DEPTH = 4,
  parameter int STARVE_LIM = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          disp_req,
  input  logic [ADDR_W-1:0]             disp_addr,
  output logic [DATA_W-1:0]             disp_rdata,
  output logic                          disp_rvalid,
  input  logic                          wr_valid,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          wr_ready,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic [$clog2(WBUF_DEPTH):0]   wbuf_level,
  output logic                          wr_starve
);

  localparam int PW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int LW = $clog2(WBUF_DEPTH) + 1;
  localparam int CW = $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] buf_addr [WBUF_DEPTH];
  logic [DATA_W-1:0] buf_data [WBUF_DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [LW-1:0]     level;
  logic [CW-1:0]     starve_cnt;
  logic              full;
  logic              push;
  logic              pop;
  logic              starving;

  // wr_ready looks only at the registered level, so a same-cycle pop never opens a full buffer
  assign full       = (level == LW'(WBUF_DEPTH));
  assign wr_ready   = !full;
  assign push       = wr_valid && wr_ready;
  assign pop        = !disp_req && (level != '0);
  assign starving   = full && disp_req;
  assign wbuf_level = level;
  assign disp_rdata = mem_rdata;

  always_ff @(posedge clk) begin
    if (push) begin
      buf_addr[wr_ptr] <= wr_addr;
      buf_data[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      level       <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      disp_rvalid <= 1'b0;
      starve_cnt  <= '0;
      wr_starve   <= 1'b0;
    end else begin
      // state holds the op on the RAM this cycle; read data returns one cycle later
      disp_rvalid <= (state == RD);

      if (disp_req) begin
        state    <= RD;
        mem_en   <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= disp_addr;
      end else if (level != '0) begin
        state     <= WR;
        mem_en    <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= buf_addr[rd_ptr];
        mem_wdata <= buf_data[rd_ptr];
      end else begin
        state  <= IDLE;
        mem_en <= 1'b0;
        mem_we <= 1'b0;
      end

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;

      if (starving) begin
        if (starve_cnt != CW'(STARVE_LIM)) starve_cnt <= starve_cnt + 1'b1;
        if (starve_cnt >= CW'(STARVE_LIM - 1)) wr_starve <= 1'b1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// tb/tb_fb_arbiter.sv - randomized scoreboard bench for fb_arbiter
module tb_fb_arbiter;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 12;
  localparam int DEPTH  = 4;
  localparam int LIM    = 16;
  localparam int LW     = $clog2(DEPTH) + 1;

  typedef struct { int cyc; logic we; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } op_t;
  typedef struct { int cyc; logic [DATA_W-1:0] data; } rd_t;
  typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } wr_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              disp_req = 1'b0;
  logic [ADDR_W-1:0] disp_addr = '0;
  logic [DATA_W-1:0] disp_rdata;
  logic              disp_rvalid;
  logic              wr_valid = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [LW-1:0]     wbuf_level;
  logic              wr_starve;

  fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WBUF_DEPTH(DEPTH), .STARVE_LIM(LIM)) dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .wbuf_level(wbuf_level), .wr_starve(wr_starve)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] pat(logic [ADDR_W-1:0] a);
    return DATA_W'((int'(a) * 37 + 5) & 12'hFFF);
  endfunction

  // RAM environment: one-cycle read latency, write on strobe
  logic [DATA_W-1:0] ram [logic [ADDR_W-1:0]];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] = mem_wdata;
      else mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr] : pat(mem_addr);
    end
  end

  // reference model: slot-level arbitration over a queue of accepted writes
  logic [DATA_W-1:0] refmem [logic [ADDR_W-1:0]];
  op_t exp_op [$];
  rd_t exp_rd [$];
  wr_t m_fifo [$];
  int  m_cnt = 0;
  bit  m_starve = 0;
  bit  last_acc = 0;
  bit  undo_v = 0;
  logic [ADDR_W-1:0] undo_a;
  logic [DATA_W-1:0] undo_old;
  int  cyc = 0;
  int  tests = 0;
  int  fails = 0;

  function automatic logic [DATA_W-1:0] mread(logic [ADDR_W-1:0] a);
    return refmem.exists(a) ? refmem[a] : pat(a);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    int  lvl;
    op_t o;
    rd_t r;
    wr_t w;
    lvl = m_fifo.size();
    @(negedge clk);
    chk("wbuf_level", 32'(wbuf_level), 32'(lvl));
    chk("wr_ready", 32'(wr_ready), 32'(lvl < DEPTH));
    chk("wr_starve", 32'(wr_starve), 32'(m_starve));
    undo_v = 0;
    if (disp_req) begin
      o.cyc = cyc + 1; o.we = 1'b0; o.addr = disp_addr; o.data = '0;
      exp_op.push_back(o);
      r.cyc = cyc + 2; r.data = mread(disp_addr);
      exp_rd.push_back(r);
    end else if (lvl > 0) begin
      w = m_fifo.pop_front();
      o.cyc = cyc + 1; o.we = 1'b1; o.addr = w.addr; o.data = w.data;
      exp_op.push_back(o);
      undo_v = 1; undo_a = w.addr; undo_old = mread(w.addr);
      refmem[w.addr] = w.data;
    end
    last_acc = wr_valid && (lvl < DEPTH);
    if (last_acc) begin
      w.addr = wr_addr; w.data = wr_data;
      m_fifo.push_back(w);
    end
    if (lvl == DEPTH && disp_req) m_cnt = (m_cnt < LIM) ? m_cnt + 1 : LIM;
    else m_cnt = 0;
    if (m_cnt == LIM) m_starve = 1;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    // a write decided last cycle is killed before the RAM sees it
    if (undo_v) refmem[undo_a] = undo_old;
    undo_v = 0;
    m_fifo.delete(); exp_op.delete(); exp_rd.delete();
    m_cnt = 0; m_starve = 0; last_acc = 0;
    disp_req = 1'b0; wr_valid = 1'b0;
    repeat (n) begin
      @(negedge clk);
      chk("rst_level", 32'(wbuf_level), 0);
      chk("rst_ready", 32'(wr_ready), 1);
      chk("rst_mem_en", 32'(mem_en), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_mem_wdata", 32'(mem_wdata), 0);
      chk("rst_rvalid", 32'(disp_rvalid), 0);
      chk("rst_starve", 32'(wr_starve), 0);
      @(posedge clk);
      cyc++;
      #1;
    end
    rst = 1'b0;
  endtask

  task automatic offer(logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic rand_cycles(int n, int p_disp, int p_wr);
    repeat (n) begin
      disp_req  = ($urandom_range(0, 99) < p_disp);
      disp_addr = ADDR_W'($urandom_range(0, 31));
      if (!(wr_valid && !last_acc)) begin
        wr_valid = ($urandom_range(0, 99) < p_wr);
        wr_addr  = ADDR_W'($urandom_range(0, 31));
        wr_data  = DATA_W'($urandom);
      end
      step();
    end
  endtask

  // monitor: every RAM strobe and every read return must match the head of its queue
  op_t mon_o;
  rd_t mon_r;
  initial begin
    forever begin
      @(negedge clk);
      if (mem_en) begin
        if (exp_op.size() == 0) chk("unexpected_mem_en", 32'(mem_en), 0);
        else begin
          mon_o = exp_op.pop_front();
          chk("op_cycle", 32'(cyc), 32'(mon_o.cyc));
          chk("mem_we", 32'(mem_we), 32'(mon_o.we));
          chk("mem_addr", 32'(mem_addr), 32'(mon_o.addr));
          if (mon_o.we) chk("mem_wdata", 32'(mem_wdata), 32'(mon_o.data));
        end
      end
      if (disp_rvalid) begin
        if (exp_rd.size() == 0) chk("unexpected_rvalid", 32'(disp_rvalid), 0);
        else begin
          mon_r = exp_rd.pop_front();
          chk("rvalid_cycle", 32'(cyc), 32'(mon_r.cyc));
          chk("disp_rdata", 32'(disp_rdata), 32'(mon_r.data));
        end
      end
    end
  end

  initial begin
    int n_off;
    #1;
    do_reset(3);

    offer(17'h00123, 12'hF0F); step();
    wr_valid = 1'b0; repeat (3) step();
    disp_req = 1'b1; disp_addr = 17'h00123; step();
    disp_req = 1'b0; repeat (3) step();

    offer(17'h00010, 12'hABC); step();
    wr_valid = 1'b0; repeat (3) step();

    // full buffer under continuous display traffic, long enough to starve
    n_off = 0;
    disp_req = 1'b1;
    repeat (24) begin
      disp_addr = ADDR_W'($urandom_range(0, 31));
      if (!(wr_valid && !last_acc)) begin
        if (n_off < 5) begin offer(ADDR_W'(17'h40 + n_off), DATA_W'($urandom)); n_off++; end
        else wr_valid = 1'b0;
      end
      step();
    end
    disp_req = 1'b0;
    repeat (8) begin
      if (wr_valid && last_acc) wr_valid = 1'b0;
      step();
    end
    wr_valid = 1'b0;
    repeat (3) step();

    rand_cycles(300, 50, 60);

    // reset with three buffered writes and a read in flight
    wr_valid = 1'b0; repeat (6) step();
    disp_req = 1'b1;
    for (int i = 0; i < 3; i++) begin offer(ADDR_W'(17'h60 + i), DATA_W'($urandom)); step(); end
    wr_valid = 1'b0; disp_addr = 17'h00005; step();
    do_reset(2);
    repeat (5) step();

    // hold level at two while writes are pushed only on pop cycles
    disp_req = 1'b1;
    for (int i = 0; i < 2; i++) begin offer(ADDR_W'(17'h70 + i), DATA_W'($urandom)); step(); end
    for (int i = 0; i < 8; i++) begin
      disp_req = i[0];
      disp_addr = 17'h00070;
      if (!disp_req) offer(ADDR_W'(17'h70 + (i % 3)), DATA_W'($urandom));
      else wr_valid = 1'b0;
      step();
    end
    disp_req = 1'b0; wr_valid = 1'b0;
    repeat (4) step();

    rand_cycles(300, 85, 80);
    rand_cycles(200, 30, 70);

    disp_req = 1'b0; wr_valid = 1'b0;
    repeat (10) step();
    chk("ops_left", 32'(exp_op.size()), 0);
    chk("reads_left", 32'(exp_rd.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 17, pixel address width (320x240 RGB444 frame); DATA_W, default 12, pixel width {R[3:0],G[3:0],B[3:0]}; WBUF_DEPTH, default 4, write-buffer entries (power of 2); STARVE_LIM, default 16, consecutive display-owned cycles counted while the buffer is full.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 disp_req  in  1  display fetch request, at most one per cycle, never stalled.
REQ-005 disp_addr  in  ADDR_W  display fetch address, sampled with disp_req.
REQ-006 disp_rdata  out  DATA_W  fetched pixel, valid when disp_rvalid=1.
REQ-007 disp_rvalid  out  1  one-cycle pulse marking disp_rdata valid.
REQ-008 wr_valid  in  1  writer request; wr_addr/wr_data stable while wr_valid=1 and wr_ready=0.
REQ-009 wr_addr  in  ADDR_W  write address.
REQ-010 wr_data  in  DATA_W  write pixel.
REQ-011 wr_ready  out  1  buffer can accept; transfer occurs on a cycle with wr_valid=1 and wr_ready=1.
REQ-012 mem_en  out  1  single-port RAM access strobe (registered).
REQ-013 mem_we  out  1  1=write, 0=read (registered).
REQ-014 mem_addr  out  ADDR_W  RAM address (registered).
REQ-015 mem_wdata  out  DATA_W  RAM write data (registered).
REQ-016 mem_rdata  in  DATA_W  RAM read data, valid one cycle after a read strobe.
REQ-017 wbuf_level  out  log2(WBUF_DEPTH)+1  current write-buffer occupancy.
REQ-018 wr_starve  out  1  sticky starvation flag.

Function
REQ-019 Arbitration SHALL be fixed priority: disp_req at cycle N wins the slot; otherwise the oldest buffered write wins if the buffer is non-empty; otherwise the slot is idle.
REQ-020 FSM states SHALL be IDLE, RD, WR, holding the op issued to the RAM this cycle; next state = RD if disp_req, else WR if level>0, else IDLE, from every state.
REQ-021 Decision at cycle N SHALL drive mem_en/mem_we/mem_addr/mem_wdata at cycle N+1; RD: mem_en=1, mem_we=0, mem_addr=disp_addr; WR: mem_en=1, mem_we=1, addr/data = buffer head; IDLE: mem_en=0, mem_we=0, addr/wdata hold previous values.
REQ-022 disp_rvalid SHALL pulse at cycle N+2 for disp_req at N, disp_rdata = mem_rdata passthrough; back-to-back requests yield back-to-back rvalid, order preserved.
REQ-023 Write buffer SHALL be a FIFO of {addr,data}; pop occurs on the cycle the WR decision is made.
REQ-024 wr_ready SHALL equal (level < WBUF_DEPTH) from registered state only; a pop in the same cycle does not raise wr_ready when full.
REQ-025 Simultaneous push and pop SHALL leave level unchanged and preserve FIFO order; read/write pointers wrap modulo WBUF_DEPTH.
REQ-026 No forwarding: a display read of an address pending in the buffer SHALL return the RAM's old contents.
REQ-027 Starvation counter SHALL increment each cycle level==WBUF_DEPTH and disp_req=1, clear on any cycle otherwise, saturate at STARVE_LIM; wr_starve SHALL set when count reaches STARVE_LIM and stay set until reset.
REQ-028 Duplicate writes to one address SHALL both be issued, in acceptance order.

Reset
REQ-029 While rst=1: state=IDLE, pointers and level=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, disp_rvalid=0, starve count=0, wr_starve=0, wr_ready=1 (combinational from level).
REQ-030 Reset asserted mid-operation SHALL discard buffered writes and in-flight reads; no disp_rvalid SHALL appear after rst rises, including for a read issued the cycle before.
REQ-031 First decision after rst falls SHALL use inputs of that first clock edge.

Verification
REQ-032 Single read: disp_req=1, disp_addr=0x00123 at N, RAM[0x123]=0xF0F -> mem_en=1, mem_we=0, mem_addr=0x123 at N+1; disp_rvalid=1, disp_rdata=0xF0F at N+2.
REQ-033 Write in idle: wr_valid=1, wr_addr=0x00010, wr_data=0xABC, no disp_req -> wbuf_level=1 next cycle, then mem_we=1, addr 0x010, wdata 0xABC one cycle later; level returns to 0.
REQ-034 Full buffer: 5 writes offered while disp_req held high -> 4 accepted, wr_ready=0, level=4; on disp_req release writes issue in acceptance order, one per cycle.
REQ-035 Starvation: buffer full plus disp_req high 16 consecutive cycles -> wr_starve=1 on 16th count and stays 1 after disp_req drops.
REQ-036 Reset mid-flight: level=3 and read at N, rst pulsed at N+1 -> level=0, mem_en=0, no disp_rvalid, buffered writes never reach RAM.
REQ-037 Push+pop at level=2 with alternating disp_req -> level stays 2; RAM write sequence matches acceptance order exactly.
